inst_fetch_unit: RTL and testbench

Front-end fetch stage. It owns the fetch PC and issues in-order requests to instruction memory, tracking up to MAX_OUTSTANDING of them. Returned instructions are buffered in a fetch queue and presented as inst_valid/inst_pc/inst_data to the branch predictor and pre-decoder. It redirects on predictor taken (bp_taken/bp_pc) and on BPU misprediction flush (bpu_flush/bpu_target), killing wrong-path requests and queued instructions.

---
 rtl/inst_fetch_if.sv | 27 ++
 rtl/inst_fetch_unit.sv | 81 ++++++++
 tb/tb_inst_fetch_unit.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: fetch unit bus to the BPU, instruction memory and pre-decoder
interface inst_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  bpu_flush;
  logic [ADDR_WIDTH-1:0] bpu_target;
  logic                  bp_taken;
  logic [ADDR_WIDTH-1:0] bp_pc;
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rsp_data;
  logic                  inst_valid;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic [DATA_WIDTH-1:0] inst_data;
  logic                  inst_ready;
  modport master (
    input  bpu_flush, bpu_target, bp_taken, bp_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data
  );
  modport slave (
    output bpu_flush, bpu_target, bp_taken, bp_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch PC, in-order imem requests with kill tracking, registered fetch queue
module inst_fetch_unit #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter int                    FQ_DEPTH        = 4
) (
  input logic          CLK,
  input logic          RSTN,
  inst_fetch_if.master bus
);
  localparam int TW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int FW = FQ_DEPTH > 1 ? $clog2(FQ_DEPTH) : 1;
  localparam int CW = $clog2(FQ_DEPTH + 1);

  logic [ADDR_WIDTH-1:0]      pc_q;
  logic [ADDR_WIDTH-1:0]      trk_pc [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] trk_kill;
  logic [MAX_OUTSTANDING-1:0] wr_mask;
  logic [TW-1:0]              trk_wr, trk_rd;
  logic [OW-1:0]              outstanding;
  logic [ADDR_WIDTH-1:0]      fq_pc [FQ_DEPTH];
  logic [DATA_WIDTH-1:0]      fq_data [FQ_DEPTH];
  logic [FW-1:0]              fq_wr, fq_rd;
  logic [CW-1:0]              fq_count;
  logic [ADDR_WIDTH-1:0]      redirect_pc;
  logic                       fq_empty, accept, predict, redirect, rsp_pop, fq_push;

  function automatic logic [TW-1:0] trk_inc(input logic [TW-1:0] p);
    return p == TW'(MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction

  // Credit counts killed entries too, so the queue can never overflow when they land
  always_comb begin
    fq_empty           = fq_count == '0;
    bus.imem_req_valid = RSTN && 32'(outstanding) < MAX_OUTSTANDING &&
                         32'(outstanding) + 32'(fq_count) < FQ_DEPTH && !bus.bpu_flush;
    bus.imem_req_addr  = pc_q;
    accept             = bus.imem_req_valid && bus.imem_req_ready;
    bus.inst_valid     = !fq_empty && bus.inst_ready && !bus.bpu_flush;
    bus.inst_pc        = fq_empty ? '0 : fq_pc[fq_rd];
    bus.inst_data      = fq_empty ? '0 : fq_data[fq_rd];
    predict            = bus.inst_valid && bus.bp_taken;
    redirect           = bus.bpu_flush || predict;
    redirect_pc        = (bus.bpu_flush ? bus.bpu_target : bus.bp_pc) & ~ADDR_WIDTH'(3);
    rsp_pop            = bus.imem_rsp_valid && outstanding != '0;
    fq_push            = rsp_pop && !trk_kill[trk_rd] && !redirect;
    wr_mask            = MAX_OUTSTANDING'(accept) << trk_wr;
  end

  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      pc_q        <= RESET_PC & ~ADDR_WIDTH'(3);
      trk_kill    <= '0;
      trk_wr      <= '0;
      trk_rd      <= '0;
      outstanding <= '0;
      fq_wr       <= '0;
      fq_rd       <= '0;
      fq_count    <= '0;
    end else begin
      pc_q        <= redirect ? redirect_pc : accept ? pc_q + ADDR_WIDTH'(4) : pc_q;
      trk_kill    <= (trk_kill & ~wr_mask) | {MAX_OUTSTANDING{redirect}};
      trk_wr      <= accept ? trk_inc(trk_wr) : trk_wr;
      trk_rd      <= rsp_pop ? trk_inc(trk_rd) : trk_rd;
      outstanding <= outstanding + OW'(accept) - OW'(rsp_pop);
      fq_wr       <= redirect ? '0 : fq_wr + FW'(fq_push);
      fq_rd       <= redirect ? '0 : fq_rd + FW'(bus.inst_valid);
      fq_count    <= redirect ? '0 : fq_count + CW'(fq_push) - CW'(bus.inst_valid);
    end

  always_ff @(posedge CLK) begin
    if (accept) trk_pc[trk_wr] <= pc_q;
    if (fq_push) begin
      fq_pc[fq_wr]   <= trk_pc[trk_rd];
      fq_data[fq_wr] <= bus.imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: vector table, directed redirect sequences and a randomized run against a queue model
module tb_inst_fetch_unit;
  localparam int AW = 32, DW = 32, MAXO = 2, FQD = 4;
  logic CLK = 0, RSTN = 1;
  always #5 CLK = ~CLK;

  inst_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  inst_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'h0), .MAX_OUTSTANDING(MAXO), .FQ_DEPTH(FQD))
    dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));

  typedef struct { logic [31:0] addr; int due; bit live; } req_t;
  typedef struct { bit ir; bit rv; logic [31:0] ra; bit iv; logic [31:0] ipc; } vec_t;

  req_t        mem_q[$];
  logic [31:0] fq_m[$];
  logic [31:0] exp_req_pc, exp_next, drv_target, drv_bpp, bp_match;
  int          cyc, lat, n_chk, n_fail;
  bit          drv_ir, drv_rdy, drv_flush, drv_bpt, bp_en, saw_wrap, last_top, saw_300;
  vec_t        tbl[16];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    chk(name, 32'(got), 32'(exp));
  endtask

  // Drive one cycle at the negedge, check outputs against the model, then advance the model
  task automatic eval();
    req_t        h;
    bit          erv, eiv, acc, take, redir;
    logic [31:0] tgt;
    bus.inst_ready     = drv_ir;
    bus.imem_req_ready = drv_rdy;
    bus.bpu_flush      = drv_flush;
    bus.bpu_target     = drv_target;
    bus.bp_pc          = drv_bpp;
    bus.bp_taken       = drv_bpt | (bp_en && bus.inst_pc == bp_match);
    bus.imem_rsp_valid = mem_q.size() > 0 && mem_q[0].due <= cyc;
    bus.imem_rsp_data  = bus.imem_rsp_valid ? memf(mem_q[0].addr) : $urandom;
    #1;
    erv = mem_q.size() < MAXO && mem_q.size() + fq_m.size() < FQD && !drv_flush;
    eiv = fq_m.size() > 0 && drv_ir && !drv_flush;
    chk1("req_valid", bus.imem_req_valid, erv);
    if (erv) chk("req_addr", bus.imem_req_addr, exp_req_pc);
    chk1("inst_valid", bus.inst_valid, eiv);
    chk("inst_pc", bus.inst_pc, fq_m.size() > 0 ? fq_m[0] : 32'h0);
    chk("inst_data", bus.inst_data, fq_m.size() > 0 ? memf(fq_m[0]) : 32'h0);
    if (eiv) chk("stream_pc", bus.inst_pc, exp_next);
    acc   = bus.imem_req_valid && drv_rdy;
    take  = eiv && bus.bp_taken;
    redir = drv_flush || take;
    tgt   = (drv_flush ? drv_target : drv_bpp) & ~32'h3;
    if (acc && bus.imem_req_addr == 32'h300) saw_300 = 1;
    if (bus.imem_rsp_valid) begin
      h = mem_q.pop_front();
      if (h.live && !redir) fq_m.push_back(h.addr);
    end
    if (eiv) begin
      void'(fq_m.pop_front());
      exp_next = take ? tgt : exp_next + 32'd4;
    end
    if (redir) begin
      fq_m.delete();
      foreach (mem_q[i]) mem_q[i].live = 0;
      if (drv_flush) exp_next = tgt;
    end
    if (acc) begin
      if (last_top && exp_req_pc == 32'h0) saw_wrap = 1;
      last_top = exp_req_pc == 32'hFFFF_FFFC;
      mem_q.push_back('{addr: bus.imem_req_addr, due: cyc + lat, live: !redir});
      exp_req_pc += 32'd4;
    end
    if (redir) begin
      exp_req_pc = tgt;
      last_top = 0;
    end
    chk1("outstanding_le_max", mem_q.size() <= MAXO, 1'b1);
    cyc++;
  endtask

  task automatic adv();
    @(negedge CLK);
  endtask

  task automatic step();
    eval();
    adv();
  endtask

  task automatic do_reset();
    #2 RSTN = 0;
    #1;
    chk1("rst_req_valid", bus.imem_req_valid, 1'b0);
    chk1("rst_inst_valid", bus.inst_valid, 1'b0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    chk("rst_inst_data", bus.inst_data, 32'h0);
    bus.imem_rsp_valid = 0;
    bus.bpu_flush = 0;
    bus.bp_taken = 0;
    repeat (2) @(negedge CLK);
    RSTN = 1;
    mem_q.delete();
    fq_m.delete();
    exp_req_pc = 0;
    exp_next = 0;
    cyc = 0;
    lat = 1;
    {drv_ir, drv_rdy, drv_flush, drv_bpt, bp_en, last_top} = 6'b010000;
    drv_target = 0;
    drv_bpp = 0;
  endtask

  task automatic wait_inst(input string name, input logic [31:0] pc);
    bit got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      eval();
      if (bus.inst_valid) begin
        got = 1;
        chk(name, bus.inst_pc, pc);
      end
      adv();
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no inst_valid within 30 cycles, expected pc %h", name, pc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    bus.inst_ready = 0; bus.imem_req_ready = 0; bus.bpu_flush = 0; bus.bpu_target = 0;
    bus.bp_taken = 0; bus.bp_pc = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0;
    // Downstream stalled from reset: queue fills to 4, credit stops requests, then drains in order
    for (int k = 0; k < 16; k++) tbl[k] = '{k >= 10, 1'b0, 32'h10, 1'b0, 32'h0};
    tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b0, 32'h00};
    tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b0, 32'h00};
    tbl[10] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
    tbl[11] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
    tbl[12] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
    tbl[13] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
    tbl[14] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    tbl[15] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drv_ir = tbl[k].ir;
      eval();
      chk1($sformatf("tbl%0d_req_valid", k), bus.imem_req_valid, tbl[k].rv);
      chk($sformatf("tbl%0d_req_addr", k), bus.imem_req_addr, tbl[k].ra);
      chk1($sformatf("tbl%0d_inst_valid", k), bus.inst_valid, tbl[k].iv);
      chk($sformatf("tbl%0d_inst_pc", k), bus.inst_pc, tbl[k].ipc);
      adv();
    end

    // Streaming: first instruction two cycles after the first accept, then one per cycle
    do_reset();
    drv_ir = 1;
    for (int k = 0; k < 8; k++) begin
      eval();
      chk($sformatf("stream%0d_addr", k), bus.imem_req_addr, 32'(4 * k));
      chk1($sformatf("stream%0d_iv", k), bus.inst_valid, k >= 2);
      if (k >= 2) chk($sformatf("stream%0d_pc", k), bus.inst_pc, 32'(4 * (k - 2)));
      adv();
    end

    // Predicted taken at 0x8 with younger requests in flight
    do_reset();
    lat = 2; drv_ir = 1; bp_en = 1; bp_match = 32'h8; drv_bpp = 32'h101;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      eval();
      found = bus.inst_valid && bus.bp_taken;
      adv();
    end
    chk1("bp_taken_seen", found, 1'b1);
    bp_en = 0;
    wait_inst("bp_next_pc", 32'h100);

    // Flush while the queue holds three entries
    do_reset();
    repeat (4) step();
    drv_ir = 1; drv_flush = 1; drv_target = 32'h202;
    eval();
    chk1("flush_inst_valid", bus.inst_valid, 1'b0);
    chk1("flush_req_valid", bus.imem_req_valid, 1'b0);
    adv();
    drv_flush = 0;
    eval();
    chk1("post_flush_fq_empty", bus.inst_valid, 1'b0);
    chk1("post_flush_req_valid", bus.imem_req_valid, 1'b1);
    chk("post_flush_req_addr", bus.imem_req_addr, 32'h200);
    adv();
    wait_inst("flush_next_pc", 32'h200);

    // Flush and predicted taken together: flush target wins
    do_reset();
    repeat (3) step();
    saw_300 = 0;
    drv_ir = 1; drv_bpt = 1; drv_bpp = 32'h300; drv_flush = 1; drv_target = 32'h400;
    eval();
    chk1("both_inst_valid", bus.inst_valid, 1'b0);
    adv();
    drv_bpt = 0; drv_flush = 0;
    wait_inst("both_next_pc", 32'h400);
    repeat (10) step();
    chk1("no_fetch_300", saw_300, 1'b0);

    // Random ready/backpressure/redirects, 3-cycle memory, starting just below the wrap point
    do_reset();
    lat = 3; saw_wrap = 0;
    drv_flush = 1; drv_target = 32'hFFFF_FFF4;
    step();
    drv_flush = 0;
    for (int k = 0; k < 3000; k++) begin
      drv_rdy = $urandom_range(0, 1) == 1;
      drv_ir  = $urandom_range(0, 3) != 0;
      if (k >= 40) begin
        drv_bpt    = $urandom_range(0, 15) == 0;
        drv_bpp    = $urandom_range(0, 3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        drv_flush  = $urandom_range(0, 63) == 0;
        drv_target = $urandom_range(0, 3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      end
      step();
    end
    chk1("wrap_seen", saw_wrap, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
